// File: rtl/lcd_timing_pkg.sv
// Shared LCD timing definitions for the pixel writer and the pixel reader.
// Holds the default panel geometry, the colour channel width, the reader
// state encoding and the idle levels of the interface control lines.
package lcd_timing_pkg;

    localparam int HOR_PIX_DEF = 480;
    localparam int VER_PIX_DEF = 272;
    localparam int RGB_W       = 8;

    // dclk + hsync + vsync + den + three colour channels
    localparam int BUS_W = 4 + 3 * RGB_W;

    localparam logic DCLK_IDLE  = 1'b0;
    localparam logic HSYNC_IDLE = 1'b1;
    localparam logic VSYNC_IDLE = 1'b1;
    localparam logic DEN_IDLE   = 1'b0;

    typedef enum logic {
        SEEK,
        FRAME
    } state_t;

endpackage

// File: rtl/lcd_pixel_reader_if.sv
// Parallel RGB LCD bus between the pixel writer (master) and the reader
// (slave).
//   lcd_dclk                         pixel clock, gated between frames
//   lcd_hsync / lcd_vsync            active-low line / frame sync
//   lcd_den                          active-high data enable
//   lcd_red / lcd_green / lcd_blue   pixel data
interface lcd_pixel_reader_if;
    import lcd_timing_pkg::*;

    logic             lcd_dclk;
    logic             lcd_hsync;
    logic             lcd_vsync;
    logic             lcd_den;
    logic [RGB_W-1:0] lcd_red;
    logic [RGB_W-1:0] lcd_green;
    logic [RGB_W-1:0] lcd_blue;

    modport master (
        output lcd_dclk, lcd_hsync, lcd_vsync, lcd_den,
        output lcd_red, lcd_green, lcd_blue
    );

    modport slave (
        input lcd_dclk, lcd_hsync, lcd_vsync, lcd_den,
        input lcd_red, lcd_green, lcd_blue
    );

endinterface

// File: rtl/lcd_input_sync.sv
// Two-flop bus synchronizer with a per-bit reset value.
//   clk     destination clock
//   rst_n   asynchronous active-low reset (flops load RST_VAL)
//   d       asynchronous input bus
//   q       synchronized bus, two clk cycles after d
module lcd_input_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/lcd_pixel_reader.sv
// Receive side of the parallel RGB LCD interface. Oversamples the bus in
// clk_48mhz, samples on the synchronized dclk falling edge, rebuilds pixel
// coordinates and flags malformed line/frame geometry.
//   clk_48mhz, reset_n        system clock, async active-low reset
//   lcd                       LCD bus (slave modport)
//   err_clear                 one-cycle pulse clearing both sticky errors
//   pixel_rgb/x/y, pixel_valid  captured pixel and its one-cycle strobe
//   frame_start, frame_done   frame boundary / good-frame pulses
//   line_err, frame_err       sticky geometry errors
module lcd_pixel_reader
    import lcd_timing_pkg::*;
#(
    parameter int HOR_PIX = HOR_PIX_DEF,
    parameter int VER_PIX = VER_PIX_DEF,
    parameter int COORD_W = 16
) (
    input  logic                 clk_48mhz,
    input  logic                 reset_n,
    lcd_pixel_reader_if.slave    lcd,
    input  logic                 err_clear,
    output logic [3*RGB_W-1:0]   pixel_rgb,
    output logic [COORD_W-1:0]   pixel_x,
    output logic [COORD_W-1:0]   pixel_y,
    output logic                 pixel_valid,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 line_err,
    output logic                 frame_err
);

    localparam logic [COORD_W-1:0] HOR_C    = COORD_W'(HOR_PIX);
    localparam logic [COORD_W-1:0] VER_C    = COORD_W'(VER_PIX);
    localparam logic [COORD_W-1:0] VER_LAST = COORD_W'(VER_PIX - 1);
    localparam logic [BUS_W-1:0]   SYNC_RST =
        {DCLK_IDLE, HSYNC_IDLE, VSYNC_IDLE, DEN_IDLE, {(3*RGB_W){1'b0}}};

    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (v == '1) ? v : v + COORD_W'(1);
    endfunction

    logic [BUS_W-1:0]     bus_raw, bus_s;
    logic                 dclk_s2, dclk_s3, hsync_s, vsync_s, den_s, sample;
    logic [3*RGB_W-1:0]   rgb_s;

    assign bus_raw = {lcd.lcd_dclk, lcd.lcd_hsync, lcd.lcd_vsync, lcd.lcd_den,
                      lcd.lcd_red, lcd.lcd_green, lcd.lcd_blue};

    lcd_input_sync #(
        .WIDTH   (BUS_W),
        .RST_VAL (SYNC_RST)
    ) u_sync (
        .clk   (clk_48mhz),
        .rst_n (reset_n),
        .d     (bus_raw),
        .q     (bus_s)
    );

    assign {dclk_s2, hsync_s, vsync_s, den_s, rgb_s} = bus_s;

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) dclk_s3 <= DCLK_IDLE;
        else          dclk_s3 <= dclk_s2;
    end

    // dclk falling edge: mid-eye for data launched on the rising edge
    assign sample = !dclk_s2 && dclk_s3;

    state_t               state, state_n;
    logic [COORD_W-1:0]   x, x_n, y, y_n, lines_done, lines_n;
    logic                 prev_den, prev_den_n, prev_vsync, prev_vsync_n;
    logic                 frame_bad, bad_n;
    logic                 set_line, set_frame, boundary;
    logic                 valid_n, fstart_n, fdone_n, line_err_n, frame_err_n;
    logic [3*RGB_W-1:0]   rgb_n;
    logic [COORD_W-1:0]   px_n, py_n;

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SEEK;
            x           <= '0;
            y           <= '0;
            lines_done  <= '0;
            prev_den    <= DEN_IDLE;
            prev_vsync  <= VSYNC_IDLE;
            frame_bad   <= 1'b0;
            pixel_rgb   <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            x           <= x_n;
            y           <= y_n;
            lines_done  <= lines_n;
            prev_den    <= prev_den_n;
            prev_vsync  <= prev_vsync_n;
            frame_bad   <= bad_n;
            pixel_rgb   <= rgb_n;
            pixel_x     <= px_n;
            pixel_y     <= py_n;
            pixel_valid <= valid_n;
            frame_start <= fstart_n;
            frame_done  <= fdone_n;
            line_err    <= line_err_n;
            frame_err   <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        x_n          = x;
        y_n          = y;
        lines_n      = lines_done;
        prev_den_n   = prev_den;
        prev_vsync_n = prev_vsync;
        bad_n        = frame_bad;
        set_line     = 1'b0;
        set_frame    = 1'b0;
        boundary     = 1'b0;
        valid_n      = 1'b0;
        fstart_n     = 1'b0;
        fdone_n      = 1'b0;
        rgb_n        = pixel_rgb;
        px_n         = pixel_x;
        py_n         = pixel_y;

        if (sample) begin
            prev_den_n   = den_s;
            prev_vsync_n = vsync_s;
            unique case (state)
                SEEK: begin
                    if (!vsync_s) begin
                        state_n  = FRAME;
                        x_n      = '0;
                        y_n      = '0;
                        lines_n  = '0;
                        bad_n    = 1'b0;
                        fstart_n = 1'b1;
                    end
                end
                FRAME: begin
                    // Steps are applied in order on x_n/y_n so a pixel in
                    // the vsync sample lands at (0,0).
                    if (!vsync_s && prev_vsync) begin
                        boundary  = 1'b1;
                        set_frame = (lines_done != VER_C);
                        x_n       = '0;
                        y_n       = '0;
                        lines_n   = '0;
                        bad_n     = 1'b0;
                        fstart_n  = 1'b1;
                    end
                    if (!hsync_s) x_n = '0;
                    if (den_s) begin
                        if (x_n < HOR_C) begin
                            if (y_n < VER_C) begin
                                valid_n = 1'b1;
                                rgb_n   = rgb_s;
                                px_n    = x_n;
                                py_n    = y_n;
                            end
                            x_n = sat_inc(x_n);
                        end else begin
                            set_line = 1'b1;
                            bad_n    = 1'b1;
                        end
                        if (y_n >= VER_C) begin
                            set_frame = 1'b1;
                            bad_n     = 1'b1;
                        end
                    end else if (prev_den && !boundary) begin
                        // End of line is judged on the registered x, so an
                        // hsync arriving with the den fall does not mask it.
                        // A den fall coinciding with vsync belongs to the
                        // discarded frame and is not counted.
                        if (x != HOR_C) begin
                            set_line = 1'b1;
                            bad_n    = 1'b1;
                        end
                        fdone_n = (y == VER_LAST) && !frame_bad && (x == HOR_C);
                        x_n     = '0;
                        y_n     = sat_inc(y);
                        lines_n = sat_inc(lines_done);
                    end
                end
                default: state_n = SEEK;
            endcase
        end

        // set takes priority over a simultaneous clear
        line_err_n  = (line_err  && !err_clear) || set_line;
        frame_err_n = (frame_err && !err_clear) || set_frame;
    end

endmodule

// File: tb/tb_lcd_pixel_reader.sv
// Self-checking bench for lcd_pixel_reader with a 4x3 panel and dclk=clk/4.
module tb_lcd_pixel_reader;

    localparam int HP = 4;
    localparam int VP = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        err_clear = 1'b0;
    logic [23:0] pixel_rgb;
    logic [15:0] pixel_x, pixel_y;
    logic        pixel_valid, frame_start, frame_done, line_err, frame_err;

    lcd_pixel_reader_if lcd();

    lcd_pixel_reader #(
        .HOR_PIX (HP),
        .VER_PIX (VP),
        .COORD_W (16)
    ) dut (
        .clk_48mhz   (clk),
        .reset_n     (reset_n),
        .lcd         (lcd),
        .err_clear   (err_clear),
        .pixel_rgb   (pixel_rgb),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .line_err    (line_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       vs;
        logic       hs;
        logic       den;
        logic [7:0] val;
        logic       exp_valid;
        int         ex;
        int         ey;
        int         pause;
        logic       clr;
    } vec_t;

    vec_t        vecs[$];
    logic [55:0] sb[$];
    int checks = 0, failures = 0;
    int fs_cnt = 0, fd_cnt = 0, pix_cnt = 0, fall_cyc = 0;
    int exp_fs = 0, exp_fd = 0, exp_pix = 0;

    function automatic logic [23:0] rgb_of(input logic [7:0] v);
        return {v, ~v, v ^ 8'h5a};
    endfunction

    function automatic vec_t mk(input logic vs, input logic hs, input logic den,
                                input logic [7:0] val, input logic ev,
                                input int ex, input int ey, input int pause,
                                input logic clr);
        vec_t v;
        v.vs = vs; v.hs = hs; v.den = den; v.val = val; v.exp_valid = ev;
        v.ex = ex; v.ey = ey; v.pause = pause; v.clr = clr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vsync();
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 0, 1'b0));
    endtask

    // hsync, porch, npix den pixels, den low; pause after pixel pause_x
    task automatic add_line(input int y, input int npix, input int pause_x, input logic clr_last);
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 0, 1'b0));
        for (int x = 0; x < npix; x++)
            vecs.push_back(mk(1'b1, 1'b1, 1'b1, 8'(y * 16 + x), (x < HP) && (y < VP),
                              x, y, (x == pause_x) ? 200 : 0,
                              clr_last && (x == npix - 1)));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 0, 1'b0));
    endtask

    task automatic tick(input vec_t v);
        @(posedge clk); #1;
        lcd.lcd_vsync = v.vs;
        lcd.lcd_hsync = v.hs;
        lcd.lcd_den   = v.den;
        lcd.lcd_red   = v.val;
        lcd.lcd_green = ~v.val;
        lcd.lcd_blue  = v.val ^ 8'h5a;
        lcd.lcd_dclk  = 1'b1;
        if (v.exp_valid) begin
            sb.push_back({rgb_of(v.val), 16'(v.ex), 16'(v.ey)});
            exp_pix++;
        end
        repeat (2) @(posedge clk); #1;
        lcd.lcd_dclk = 1'b0;
        fall_cyc = cyc;
        if (v.clr) begin
            // err_clear high across the edge that registers the error
            repeat (2) @(posedge clk); #1;
            err_clear = 1'b1;
            @(posedge clk); #1;
            err_clear = 1'b0;
        end else begin
            @(posedge clk);
        end
        repeat (v.pause) @(posedge clk);
    endtask

    task automatic apply();
        foreach (vecs[i]) tick(vecs[i]);
        vecs.delete();
        repeat (8) @(posedge clk);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic monitor();
        logic [55:0] e;
        forever begin
            @(negedge clk);
            if (frame_start) fs_cnt++;
            if (frame_done)  fd_cnt++;
            if (pixel_valid) begin
                pix_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pixel: got x=%0d y=%0d rgb=0x%0h, required no pixel_valid",
                             pixel_x, pixel_y, pixel_rgb);
                end else begin
                    e = sb.pop_front();
                    check("pixel_rgb_xy", 64'({pixel_rgb, pixel_x, pixel_y}), 64'(e));
                    check("pixel_latency", 64'(cyc - fall_cyc), 64'(3));
                end
            end
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_start"}, 64'(fs_cnt), 64'(exp_fs));
        check({tag, "_frame_done"},  64'(fd_cnt), 64'(exp_fd));
        check({tag, "_pixels"},      64'(pix_cnt), 64'(exp_pix));
        check({tag, "_sb_empty"},    64'(sb.size()), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            monitor();
        join_none

        lcd.lcd_dclk = 1'b0; lcd.lcd_hsync = 1'b1; lcd.lcd_vsync = 1'b1;
        lcd.lcd_den = 1'b0; lcd.lcd_red = '0; lcd.lcd_green = '0; lcd.lcd_blue = '0;

        // reset state
        repeat (3) @(posedge clk); #1;
        check("reset_data", 64'({pixel_rgb, pixel_x, pixel_y}), 64'(0));
        check("reset_flags", 64'({pixel_valid, frame_start, frame_done, line_err, frame_err}), 64'(0));
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // two clean frames
        for (int f = 0; f < 2; f++) begin
            add_vsync();
            for (int y = 0; y < VP; y++) add_line(y, HP, -1, 1'b0);
        end
        apply();
        exp_fs += 2; exp_fd += 2;
        check_counts("clean");
        check("clean_line_err", 64'(line_err), 64'(0));
        check("clean_frame_err", 64'(frame_err), 64'(0));

        // overlong line: x=4 dropped, frame_done suppressed
        add_vsync();
        add_line(0, HP + 1, -1, 1'b0);
        for (int y = 1; y < VP; y++) add_line(y, HP, -1, 1'b0);
        apply();
        exp_fs += 1;
        check_counts("overlong");
        check("overlong_line_err", 64'(line_err), 64'(1));
        check("overlong_frame_err", 64'(frame_err), 64'(0));
        pulse_clear();
        check("cleared_line_err", 64'(line_err), 64'(0));

        // short frame (2 lines) detected at the following vsync
        add_vsync();
        for (int y = 0; y < 2; y++) add_line(y, HP, -1, 1'b0);
        apply();
        exp_fs += 1;
        check("short_before_vsync_frame_err", 64'(frame_err), 64'(0));
        add_vsync();
        for (int y = 0; y < VP; y++) add_line(y, HP, -1, 1'b0);
        apply();
        exp_fs += 1; exp_fd += 1;
        check_counts("short");
        check("short_frame_err", 64'(frame_err), 64'(1));
        check("short_line_err", 64'(line_err), 64'(0));
        pulse_clear();
        check("cleared_frame_err", 64'(frame_err), 64'(0));

        // dclk stopped for 200 cycles mid-line
        add_vsync();
        add_line(0, HP, -1, 1'b0);
        add_line(1, HP, 1, 1'b0);
        add_line(2, HP, -1, 1'b0);
        apply();
        exp_fs += 1; exp_fd += 1;
        check_counts("pause");
        check("pause_errs", 64'({line_err, frame_err}), 64'(0));

        // err_clear coincident with a new line error
        add_vsync();
        add_line(0, HP + 1, -1, 1'b1);
        apply();
        exp_fs += 1;
        check_counts("collide");
        check("collide_line_err", 64'(line_err), 64'(1));

        // reset mid-line
        add_vsync();
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 0, 1'b0));
        for (int x = 0; x < 2; x++)
            vecs.push_back(mk(1'b1, 1'b1, 1'b1, 8'(x + 8'h30), 1'b1, x, 0, 0, 1'b0));
        apply();
        exp_fs += 1;
        check_counts("midline");
        check("midline_pixel_x", 64'(pixel_x), 64'(1));
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_data", 64'({pixel_rgb, pixel_x, pixel_y}), 64'(0));
        check("async_reset_flags", 64'({pixel_valid, frame_start, frame_done, line_err, frame_err}), 64'(0));
        repeat (3) @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // SEEK ignores den and hsync until vsync
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 0, 1'b0));
        for (int x = 0; x < HP; x++)
            vecs.push_back(mk(1'b1, 1'b1, 1'b1, 8'(x), 1'b0, 0, 0, 0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 0, 1'b0));
        apply();
        check_counts("seek");

        // recovery frame after reset
        add_vsync();
        for (int y = 0; y < VP; y++) add_line(y, HP, -1, 1'b0);
        apply();
        exp_fs += 1; exp_fd += 1;
        check_counts("recover");
        check("recover_errs", 64'({line_err, frame_err}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_pixel_reader.md
Name: lcd_pixel_reader

Overview:
- Receive end of the parallel RGB LCD interface driven by the GPU palette stage's pixel writer: consumes dclk/hsync/vsync/den/RGB, rebuilds (x,y) coordinates and emits one pixel strobe per active pixel.
- Used for display loopback capture and as an in-silicon timing checker: sticky errors flag malformed line or frame geometry.
- Oversamples the interface in its own system clock domain; dclk is an input signal, never a clock.

Parameters:
- HOR_PIX, 480, active pixels per line.
- VER_PIX, 272, active lines per frame.
- COORD_W, 16, width of pixel_x/pixel_y.

Ports:
- clk_48mhz  input  1  system clock; must be at least 4x the lcd_dclk frequency.
- reset_n  input  1  asynchronous active-low reset.
- lcd_dclk  input  1  pixel clock from the writer; gated, may stop between frames.
- lcd_hsync  input  1  active-low line sync.
- lcd_vsync  input  1  active-low frame sync.
- lcd_den  input  1  data enable, active high.
- lcd_red, lcd_green, lcd_blue  input  8 each  pixel data.
- err_clear  input  1  synchronous one-cycle pulse that clears both sticky errors.
- pixel_rgb  output  24  captured pixel {R,G,B}.
- pixel_x, pixel_y  output  COORD_W each  pixel coordinates.
- pixel_valid  output  1  one-cycle strobe; no backpressure.
- frame_start  output  1  one-cycle pulse on vsync.
- frame_done  output  1  one-cycle pulse after a geometrically correct frame.
- line_err, frame_err  output  1 each  sticky error flags.

Behaviour:
- Reset: all outputs 0; state SEEK; counters 0. Sync flops reset to idle levels (dclk=0, hsync=1, vsync=1, den=0) so reset release causes no false edge. Reset mid-frame discards the frame.
- Input sync: all 28 interface bits pass through 2 flops, then a third dclk flop for edge detection. Sample point = synchronized dclk falling edge (dclk_s2=0, dclk_s3=1). The writer launches on the dclk rising edge, so the falling edge is mid-eye.
- Latency: pixel_valid asserts 3 clk_48mhz cycles after the lcd_dclk falling edge. Outputs are registered.
- State machine:
  - SEEK: ignores den and hsync. At a sample with vsync=0, go to FRAME and pulse frame_start.
  - FRAME: at each sample, evaluate in priority order:
    1. vsync=0 (frame boundary):
       - If lines_done != VER_PIX, set frame_err.
       - Then x=0, y=0, lines_done=0, pulse frame_start.
       - Further vsync=0 samples on following dclks do not re-pulse; frame_start is edge-triggered on vsync falling.
    2. hsync=0: x=0.
    3. den=1:
       - If x < HOR_PIX: present pixel_rgb, pixel_x=x, pixel_y=y with pixel_valid=1; x<=x+1.
       - Otherwise: drop the pixel and set line_err.
       - If y >= VER_PIX: drop the pixel and set frame_err.
    4. den falling (previous sample den=1, current den=0) = end of line:
       - If x != HOR_PIX, set line_err.
       - y<=y+1, lines_done<=lines_done+1, x<=0.
       - If this was line VER_PIX-1 and no error occurred in this frame, pulse frame_done.
- den=1 in the same sample as vsync=0 is a valid pixel at (0,0); the boundary is processed first.
- dclk stopping (writer buffer empty or prerender): no samples occur, all state holds indefinitely, no timeout.
- Counters saturate at 2^COORD_W-1 and never wrap.
- Sticky errors: set on the event and held until err_clear. Set and clear in the same cycle: set wins.
- pixel_valid has a maximum rate of one per 4 clk_48mhz cycles; the consumer must accept every strobe.

Decomposition:
- lcd_timing_pkg: HOR_PIX/VER_PIX defaults, RGB_W=8, state enum {SEEK, FRAME}, idle levels of the sync signals. These are shared with the pixel writer.
- Sub-module lcd_input_sync: parameterized-width 2-flop bus synchronizer with per-bit reset values; the reader instantiates it once for all 28 bits.

Test Plan:
- Bench uses HOR_PIX=4, VER_PIX=3, dclk=clk/4.
- Reset then 2 clean frames (vsync, 3 lines of 4 den pixels, RGB = y*16+x) -> 12 pixel_valid per frame, coordinates (0,0)..(3,2), RGB matches, frame_start x2, frame_done x2, no errors.
- Line with 5 den pixels -> pixel at x=4 dropped, line_err=1, frame_done suppressed; err_clear -> line_err=0.
- Frame with only 2 lines, then vsync -> frame_err=1 at vsync, new frame_start, next clean frame gives frame_done.
- Stop dclk for 200 cycles mid-line, then resume -> x continues without gap, no error, pixels intact.
- Assert reset_n low mid-line -> all outputs 0 immediately. Den pixels before the next vsync produce no pixel_valid (SEEK).
- err_clear in the same cycle as a new line_err -> line_err remains 1.
